// File: rtl/m1553_word_tx.sv
// MIL-STD-1553B word transmitter: 3-bit-time sync, 16 Manchester II data bits MSB first,
// odd parity. A word accepted in the last clk of a frame follows with no gap.
module m1553_word_tx #(
    parameter int CLK_PER_HALFBIT = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic        in_sync_cmd,
    output logic        tx_p,
    output logic        tx_n,
    output logic        tx_en,
    output logic        busy,
    output logic        word_done
);
    localparam int PW = (CLK_PER_HALFBIT > 1) ? $clog2(CLK_PER_HALFBIT) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_PER_HALFBIT - 1);
    localparam logic [5:0]    HB_LAST    = 6'd39;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [5:0]    hb_q, hb_d;
    logic [15:0]   word_q, word_d;
    logic          sync_cmd_q, sync_cmd_d;
    logic          par_q, par_d;
    logic          tx_p_q, tx_p_d;
    logic          tx_n_q, tx_n_d;
    logic          tx_en_q, tx_en_d;
    logic          busy_q, busy_d;
    logic          word_done_q, word_done_d;
    logic          last_clk;
    logic          accept;
    logic          level_d;

    // Bus level for one half-bit; odd half-bits of data and parity carry the inverted value.
    function automatic logic line_level(input logic [5:0]  hb,
                                        input logic [15:0] w,
                                        input logic        cmd,
                                        input logic        p);
        logic [15:0] sh;
        logic        lvl;
        sh = w << (hb[5:1] - 5'd3);
        if (hb < 6'd3)
            lvl = cmd;
        else if (hb < 6'd6)
            lvl = ~cmd;
        else if (hb < 6'd38)
            lvl = sh[15] ^ hb[0];
        else
            lvl = p ^ hb[0];
        return lvl;
    endfunction

    always_comb begin
        last_clk   = (state_q == SEND) && (hb_q == HB_LAST) && (presc_q == PRESC_LAST);
        in_ready   = (state_q == IDLE) || last_clk;
        accept     = in_valid && in_ready;

        state_d    = state_q;
        presc_d    = presc_q;
        hb_d       = hb_q;
        word_d     = word_q;
        sync_cmd_d = sync_cmd_q;
        par_d      = par_q;

        if (accept) begin
            state_d    = SEND;
            presc_d    = '0;
            hb_d       = '0;
            word_d     = in_data;
            sync_cmd_d = in_sync_cmd;
            par_d      = ~^in_data;
        end else if (state_q == SEND) begin
            if (last_clk) begin
                state_d = IDLE;
                presc_d = '0;
                hb_d    = '0;
            end else if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                hb_d    = hb_q + 6'd1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end

        // Outputs are registered, so they are derived from the next-state values.
        level_d     = line_level(hb_d, word_d, sync_cmd_d, par_d);
        tx_en_d     = (state_d == SEND);
        busy_d      = tx_en_d;
        tx_p_d      = tx_en_d && level_d;
        tx_n_d      = tx_en_d && !level_d;
        word_done_d = tx_en_d && (hb_d == HB_LAST) && (presc_d == PRESC_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            presc_q     <= '0;
            hb_q        <= '0;
            tx_p_q      <= 1'b0;
            tx_n_q      <= 1'b0;
            tx_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            hb_q        <= hb_d;
            tx_p_q      <= tx_p_d;
            tx_n_q      <= tx_n_d;
            tx_en_q     <= tx_en_d;
            busy_q      <= busy_d;
            word_done_q <= word_done_d;
        end
    end

    // Payload registers are only meaningful while SEND, so they carry no reset.
    always_ff @(posedge clk) begin
        word_q     <= word_d;
        sync_cmd_q <= sync_cmd_d;
        par_q      <= par_d;
    end

    assign tx_p      = tx_p_q;
    assign tx_n      = tx_n_q;
    assign tx_en     = tx_en_q;
    assign busy      = busy_q;
    assign word_done = word_done_q;

endmodule
